// File: rtl/sc_sched_pkg.sv
// rtl/sc_sched_pkg.sv - shared types and widths for the SC job scheduler
package sc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int NUM_W     = 6;
    localparam int NUM_LANES = 8;
    localparam int OPS_W     = NUM_W * NUM_LANES;
    localparam int RES_W     = 9;

endpackage

// File: rtl/sc_rr_arbiter.sv
// rtl/sc_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module sc_rr_arbiter
    import sc_sched_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [2*NREQ-1:0] w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_rot = {i_req, i_req} >> i_ptr;
    assign o_any = |i_req;

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW + 1)'(NREQ)) begin
            w_sum = w_sum - (IDW + 1)'(NREQ);
        end
        o_idx   = w_sum[IDW-1:0];
        o_grant = '0;
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sc_job_sched.sv
// rtl/sc_job_sched.sv - shares one SC datapath among NREQ requesters, round-robin
module sc_job_sched
    import sc_sched_pkg::*;
#(
    parameter int  NREQ       = 4,
    parameter int  TIMEOUT    = 1023,
    parameter int  CLR_CYCLES = 2,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPS_W-1:0] req_nums,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [RES_W-1:0]      resp_result,
    output logic                  resp_timeout,
    output logic                  busy,
    output logic                  dp_clr_n,
    output logic                  dp_en_in,
    output logic [OPS_W-1:0]      dp_nums,
    input  logic                  dp_en_out,
    input  logic [RES_W-1:0]      dp_result
);

    localparam int CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_CLR_LAST = CNT_W'(CLR_CYCLES);

    sched_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_job_id, w_job_id_nxt;
    logic [NREQ-1:0]  r_req_ready, w_req_ready_nxt;
    logic             r_resp_valid, w_resp_valid_nxt;
    logic [IDW-1:0]   r_resp_id, w_resp_id_nxt;
    logic [RES_W-1:0] r_resp_result, w_resp_result_nxt;
    logic             r_resp_timeout, w_resp_timeout_nxt;
    logic             r_busy;
    logic             r_dp_clr_n, w_dp_clr_n_nxt;
    logic             r_dp_en_in, w_dp_en_in_nxt;
    logic [OPS_W-1:0] r_dp_nums, w_dp_nums_nxt;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_any;
    logic [OPS_W-1:0] w_sel_nums;

    sc_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_nums = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_sel_nums = req_nums[i*OPS_W +: OPS_W];
            end
        end
    end

    // The CLEAR count starts at 0 in the accept cycle, so dp_clr_n is low for counts 1..CLR_CYCLES.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_ptr_nxt          = r_ptr;
        w_job_id_nxt       = r_job_id;
        w_req_ready_nxt    = '0;
        w_resp_valid_nxt   = 1'b0;
        w_resp_id_nxt      = r_resp_id;
        w_resp_result_nxt  = r_resp_result;
        w_resp_timeout_nxt = r_resp_timeout;
        w_dp_clr_n_nxt     = 1'b1;
        w_dp_en_in_nxt     = 1'b0;
        w_dp_nums_nxt      = r_dp_nums;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_req_ready_nxt = w_grant;
                    w_dp_nums_nxt   = w_sel_nums;
                    w_job_id_nxt    = w_gidx;
                    w_ptr_nxt       = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
                    w_cnt_nxt       = '0;
                    w_state_nxt     = CLEAR;
                end
            end
            CLEAR: begin
                if (r_cnt == CNT_CLR_LAST) begin
                    w_cnt_nxt      = '0;
                    w_dp_en_in_nxt = 1'b1;
                    w_state_nxt    = RUN;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_dp_clr_n_nxt = 1'b0;
                end
            end
            RUN: begin
                if (dp_en_out) begin
                    w_resp_result_nxt  = dp_result;
                    w_resp_timeout_nxt = 1'b0;
                    w_resp_id_nxt      = r_job_id;
                    w_resp_valid_nxt   = 1'b1;
                    w_state_nxt        = RESP;
                end else if (r_cnt == CNT_TO_LAST) begin
                    w_resp_result_nxt  = '0;
                    w_resp_timeout_nxt = 1'b1;
                    w_resp_id_nxt      = r_job_id;
                    w_resp_valid_nxt   = 1'b1;
                    w_state_nxt        = RESP;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_dp_en_in_nxt = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_resp_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_ptr          <= '0;
            r_job_id       <= '0;
            r_req_ready    <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= '0;
            r_resp_result  <= '0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
            r_dp_clr_n     <= 1'b0;
            r_dp_en_in     <= 1'b0;
            r_dp_nums      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ptr          <= w_ptr_nxt;
            r_job_id       <= w_job_id_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_id      <= w_resp_id_nxt;
            r_resp_result  <= w_resp_result_nxt;
            r_resp_timeout <= w_resp_timeout_nxt;
            r_busy         <= (w_state_nxt != IDLE);
            r_dp_clr_n     <= w_dp_clr_n_nxt;
            r_dp_en_in     <= w_dp_en_in_nxt;
            r_dp_nums      <= w_dp_nums_nxt;
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_resp_id;
    assign resp_result  = r_resp_result;
    assign resp_timeout = r_resp_timeout;
    assign busy         = r_busy;
    assign dp_clr_n     = r_dp_clr_n;
    assign dp_en_in     = r_dp_en_in;
    assign dp_nums      = r_dp_nums;

endmodule

// File: tb/tb_sc_job_sched.sv
// tb/tb_sc_job_sched.sv - randomized self-checking bench for sc_job_sched
module tb_sc_job_sched;

    localparam int NREQ       = 4;
    localparam int TIMEOUT    = 1023;
    localparam int CLR_CYCLES = 2;
    localparam int IDW        = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*48-1:0]    req_nums;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [8:0]            resp_result;
    logic                  resp_timeout;
    logic                  busy;
    logic                  dp_clr_n;
    logic                  dp_en_in;
    logic [47:0]           dp_nums;
    logic                  dp_en_out;
    logic [8:0]            dp_result;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    sc_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_nums     (req_nums),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .dp_clr_n     (dp_clr_n),
        .dp_en_in     (dp_en_in),
        .dp_nums      (dp_nums),
        .dp_en_out    (dp_en_out),
        .dp_result    (dp_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Round-robin rule: first requesting index at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_nums();
        for (int w = 0; w < NREQ * 48 / 32; w++) req_nums[w*32 +: 32] = $urandom();
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        dp_en_out  = 1'b0;
        dp_result  = '0;
        repeat (2) step();
        check("rst_dp_nums", dp_nums, 0);
        check("rst_ctrl", {req_ready, resp_valid, resp_id, resp_result, resp_timeout,
                           busy, dp_clr_n, dp_en_in}, 0);
        rst   = 1'b1;
        m_ptr = 0;
        step();
        check("idle_clr_n", dp_clr_n, 1);
    endtask

    // lat: RUN cycle index (0-based) at which dp_en_out is raised, <0 for never.
    task automatic run_job(input logic [NREQ-1:0] mask, input int lat, input logic [8:0] res,
                           input int bp, input bit spur, input int abort_at);
        int g, t, waited, n_clr, n_run, bad_nums, extra, bad_en, unstable;
        logic [47:0] exp_nums;
        logic [10:0] snap;
        logic        exp_to;
        g        = rr_pick(mask, m_ptr);
        exp_nums = req_nums[g*48 +: 48];
        req_valid = mask;
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            step();
            waited++;
        end
        check("grant", req_ready, 64'(1) << g);
        if (waited >= 20) return;
        m_ptr = (g + 1) % NREQ;
        check("accept_clr_n", dp_clr_n, 1);
        if (spur) begin
            dp_en_out = 1'b1;
            dp_result = 9'($urandom());
        end
        n_clr = 0; bad_nums = 0; extra = 0; bad_en = 0; unstable = 0;
        step();
        t = 1;
        while (!dp_en_in && t < 20) begin
            if (!dp_clr_n) n_clr++;
            if (dp_nums !== exp_nums) bad_nums++;
            if (req_ready != '0) extra++;
            step();
            t++;
        end
        dp_en_out = 1'b0;
        check("clr_cycles", n_clr, CLR_CYCLES);
        check("en_in_rise", t, CLR_CYCLES + 1);
        n_run = 0;
        while (!resp_valid && n_run < TIMEOUT + 5) begin
            if (n_run == abort_at) begin
                #2 rst = 1'b0;
                #1;
                check("arst_en_in", dp_en_in, 0);
                check("arst_clr_n", dp_clr_n, 0);
                check("arst_resp_valid", resp_valid, 0);
                check("arst_busy", busy, 0);
                req_valid = '0;
                step();
                rst   = 1'b1;
                m_ptr = 0;
                return;
            end
            if (!dp_en_in || !dp_clr_n) bad_en++;
            if (dp_nums !== exp_nums) bad_nums++;
            if (req_ready != '0) extra++;
            if (n_run == lat) begin
                dp_en_out = 1'b1;
                dp_result = res;
            end else begin
                dp_en_out = 1'b0;
            end
            step();
            n_run++;
        end
        dp_en_out = 1'b0;
        exp_to = (lat < 0 || lat >= TIMEOUT);
        check("run_len", n_run, exp_to ? TIMEOUT : lat + 1);
        check("run_en_in", bad_en, 0);
        check("resp_id", resp_id, g);
        check("resp_result", resp_result, exp_to ? 9'd0 : res);
        check("resp_timeout", resp_timeout, exp_to);
        check("resp_en_in_low", dp_en_in, 0);
        snap = {resp_id, resp_result};
        for (int i = 0; i < bp; i++) begin
            if ({resp_valid, resp_id, resp_result} !== {1'b1, snap} || resp_timeout !== exp_to)
                unstable++;
            if (dp_nums !== exp_nums) bad_nums++;
            if (req_ready != '0) extra++;
            step();
        end
        resp_ready = 1'b1;
        if (req_ready != '0) extra++;
        step();
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("idle_bubble", busy, 0);
        check("no_early_ready", extra, 0);
        check("nums_stable", bad_nums, 0);
        if (bp > 0) check("bp_stable", unstable, 0);
    endtask

    initial begin
        req_nums = '0;
        do_reset();

        for (int i = 0; i < NREQ * 8; i++) req_nums[i*6 +: 6] = 6'd32;
        run_job(4'b0100, 64, 9'h0A5, 0, 1'b0, -1);

        rand_nums();
        run_job(4'b0010, 10, 9'h1C3, 10, 1'b0, -1);

        rand_nums();
        run_job(4'b1001, -1, 9'h000, 1, 1'b0, -1);

        rand_nums();
        run_job(4'b0001, 4, 9'h123, 0, 1'b1, -1);

        rand_nums();
        run_job(4'b1000, -1, 9'h000, 0, 1'b0, 20);
        rand_nums();
        run_job(4'b1010, 7, 9'h05A, 0, 1'b0, -1);

        do_reset();
        for (int j = 0; j < 8; j++) begin
            rand_nums();
            run_job(4'b1111, int'($urandom_range(0, 40)), 9'($urandom()), 0, 1'b0, -1);
        end

        for (int j = 0; j < 20; j++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rand_nums();
            run_job(m, int'($urandom_range(0, 100)), 9'($urandom()),
                    int'($urandom_range(0, 3)), 1'($urandom()), -1);
        end

        req_valid = '0;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
